// File: rtl/strap_rst_seq_pkg.sv
// Shared types and strap bit positions for the strap reset sequencer.
package strap_pkg;

  typedef enum logic [2:0] {
    PRST,
    CLKWAIT,
    SRSTWAIT,
    RUN,
    RB_ASSERT,
    RB_HOLD
  } rst_seq_st_t;

  localparam int STRAP_SOFT_REBOOT_REQ = 31;
  localparam int STRAP_RISCV_RST       = 12;

  localparam logic [3:0] REBOOT_CNT_MAX = 4'd15;

endpackage

// File: rtl/strap_rst_seq_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clk edge.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic meta_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_n     <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      meta_n     <= 1'b1;
      rst_sync_n <= meta_n;
    end
  end

endmodule

// File: rtl/strap_rst_seq.sv
// Power-on / soft-reboot reset sequencer: e_reset_n -> p_reset_n -> clk_enb -> s_reset_n.
//
// state     | meaning
// PRST      | p_reset_n held low while straps are captured
// CLKWAIT   | p_reset_n released, waiting to open the core clock gate
// SRSTWAIT  | clock running, waiting to release the soft reset
// RUN       | sequence complete, watching for a soft-reboot request
// RB_ASSERT | soft reset just asserted, clock gate closes next
// RB_HOLD   | soft reset held until minimum time passed and request cleared
module strap_rst_seq
  import strap_pkg::*;
#(
  parameter int PRST_CYC   = 16,
  parameter int CLKEN_CYC  = 8,
  parameter int SRST_CYC   = 8,
  parameter int REBOOT_CYC = 32,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       e_reset_n,
  input  logic       strap_reboot_req,
  input  logic       strap_riscv_rst,
  input  logic       cpu_rst_release,
  output logic       p_reset_n,
  output logic       clk_enb,
  output logic       s_reset_n,
  output logic       cpu_reset_n,
  output logic       seq_busy,
  output logic [3:0] reboot_cnt
);

  localparam logic [CNT_W-1:0] PRST_LAST  = CNT_W'(PRST_CYC - 1);
  localparam logic [CNT_W-1:0] CLKEN_LAST = CNT_W'(CLKEN_CYC - 1);
  localparam logic [CNT_W-1:0] SRST_LAST  = CNT_W'(SRST_CYC - 1);
  localparam logic [CNT_W-1:0] REBOOT_MIN = CNT_W'(REBOOT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             rst_sync_n;
  logic             req_meta;
  logic             req_sync;
  logic             cpu_gate;
  rst_seq_st_t      state;
  rst_seq_st_t      state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             p_reset_nx;
  logic             clk_enb_nx;
  logic             s_reset_nx;
  logic             seq_busy_nx;
  logic [3:0]       reboot_cnt_nx;

  reset_sync u_reset_sync (
    .clk        (clk),
    .rst_n      (e_reset_n),
    .rst_sync_n (rst_sync_n)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      req_meta    <= 1'b0;
      req_sync    <= 1'b0;
      cpu_gate    <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      req_meta    <= strap_reboot_req;
      req_sync    <= req_meta;
      cpu_gate    <= strap_riscv_rst | cpu_rst_release;
      cpu_reset_n <= s_reset_n & cpu_gate;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= PRST;
      cnt        <= '0;
      p_reset_n  <= 1'b0;
      clk_enb    <= 1'b0;
      s_reset_n  <= 1'b0;
      seq_busy   <= 1'b1;
      reboot_cnt <= 4'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      p_reset_n  <= p_reset_nx;
      clk_enb    <= clk_enb_nx;
      s_reset_n  <= s_reset_nx;
      seq_busy   <= seq_busy_nx;
      reboot_cnt <= reboot_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    p_reset_nx    = p_reset_n;
    clk_enb_nx    = clk_enb;
    s_reset_nx    = s_reset_n;
    reboot_cnt_nx = reboot_cnt;

    case (state)
      PRST: begin
        if (cnt == PRST_LAST) begin
          state_nx   = CLKWAIT;
          p_reset_nx = 1'b1;
        end
      end
      CLKWAIT: begin
        if (cnt == CLKEN_LAST) begin
          state_nx   = SRSTWAIT;
          clk_enb_nx = 1'b1;
        end
      end
      SRSTWAIT: begin
        if (cnt == SRST_LAST) begin
          state_nx   = RUN;
          s_reset_nx = 1'b1;
        end
      end
      RUN: begin
        if (req_sync) begin
          state_nx   = RB_ASSERT;
          s_reset_nx = 1'b0;
        end
      end
      RB_ASSERT: begin
        state_nx   = RB_HOLD;
        clk_enb_nx = 1'b0;
      end
      RB_HOLD: begin
        // p_reset_n stays high here so the sticky straps survive the reboot
        if ((cnt >= REBOOT_MIN) && !req_sync) begin
          state_nx   = SRSTWAIT;
          clk_enb_nx = 1'b1;
          if (reboot_cnt != REBOOT_CNT_MAX) begin
            reboot_cnt_nx = reboot_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nx = PRST;
      end
    endcase

    if (state_nx != state) begin
      cnt_nx = '0;
    end
    seq_busy_nx = (state_nx != RUN);
  end

endmodule

// File: tb/tb_strap_rst_seq.sv
// Directed bench for strap_rst_seq: POR timing, cpu release, soft reboots, mid-sequence reset, saturation.
module tb_strap_rst_seq;

  localparam int PRST_CYC   = 16;
  localparam int CLKEN_CYC  = 8;
  localparam int SRST_CYC   = 8;
  localparam int REBOOT_CYC = 32;
  localparam int T_P  = 2 + PRST_CYC;
  localparam int T_CE = T_P + CLKEN_CYC;
  localparam int T_S  = T_CE + SRST_CYC;

  logic       clk = 1'b0;
  logic       e_reset_n = 1'b1;
  logic       strap_reboot_req = 1'b0;
  logic       strap_riscv_rst = 1'b1;
  logic       cpu_rst_release = 1'b0;
  logic       p_reset_n;
  logic       clk_enb;
  logic       s_reset_n;
  logic       cpu_reset_n;
  logic       seq_busy;
  logic [3:0] reboot_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  strap_rst_seq dut (
    .clk              (clk),
    .e_reset_n        (e_reset_n),
    .strap_reboot_req (strap_reboot_req),
    .strap_riscv_rst  (strap_riscv_rst),
    .cpu_rst_release  (cpu_rst_release),
    .p_reset_n        (p_reset_n),
    .clk_enb          (clk_enb),
    .s_reset_n        (s_reset_n),
    .cpu_reset_n      (cpu_reset_n),
    .seq_busy         (seq_busy),
    .reboot_cnt       (reboot_cnt)
  );

  task automatic hold_reset();
    e_reset_n        = 1'b0;
    strap_reboot_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Releases e_reset_n just after edge 0 and records the first edge each output reaches its run level.
  task automatic trace_por(output int e_p, output int e_ce, output int e_s,
                           output int e_cpu, output int e_busy);
    e_p = -1; e_ce = -1; e_s = -1; e_cpu = -1; e_busy = -1;
    @(posedge clk); #1;
    e_reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (e_p < 0 && p_reset_n)     e_p = k;
      if (e_ce < 0 && clk_enb)      e_ce = k;
      if (e_s < 0 && s_reset_n)     e_s = k;
      if (e_cpu < 0 && cpu_reset_n) e_cpu = k;
      if (e_busy < 0 && !seq_busy)  e_busy = k;
    end
  endtask

  // Raises the request just after edge 0, drops it after edge hold_cyc, and traces the reboot.
  task automatic soft_reboot(input int hold_cyc, output int k_fall, output int k_cefall,
                             output int k_cerise, output int k_up, output logic p_drop);
    k_fall = -1; k_cefall = -1; k_cerise = -1; k_up = -1; p_drop = 1'b0;
    @(posedge clk); #1;
    strap_reboot_req = 1'b1;
    for (int k = 1; k <= 400 && k_up < 0; k++) begin
      @(posedge clk); #1;
      if (k == hold_cyc) strap_reboot_req = 1'b0;
      if (!p_reset_n) p_drop = 1'b1;
      if (k_fall < 0 && !s_reset_n) k_fall = k;
      if (k_cefall < 0 && !clk_enb) k_cefall = k;
      if (k_cefall > 0 && k_cerise < 0 && clk_enb) k_cerise = k;
      if (k_fall > 0 && s_reset_n) k_up = k;
    end
    strap_reboot_req = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    e_reset_n = 1'b0;
    #1;
    n_cmp++; if (p_reset_n !== 1'b0) begin n_bad++; $display("FAIL rst_p_reset_n: got %b want 0", p_reset_n); end
    hold_reset();
    n_cmp++; if (clk_enb !== 1'b0) begin n_bad++; $display("FAIL rst_clk_enb: got %b want 0", clk_enb); end
    n_cmp++; if (s_reset_n !== 1'b0) begin n_bad++; $display("FAIL rst_s_reset_n: got %b want 0", s_reset_n); end
    n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_reset_n: got %b want 0", cpu_reset_n); end
    n_cmp++; if (seq_busy !== 1'b1) begin n_bad++; $display("FAIL rst_seq_busy: got %b want 1", seq_busy); end
    n_cmp++; if (reboot_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_reboot_cnt: got %0d want 0", reboot_cnt); end
  endtask

  task automatic test_por();
    int e_p, e_ce, e_s, e_cpu, e_busy;
    strap_riscv_rst = 1'b1;
    cpu_rst_release = 1'b0;
    hold_reset();
    trace_por(e_p, e_ce, e_s, e_cpu, e_busy);
    n_cmp++; if (e_p != T_P) begin n_bad++; $display("FAIL por_p_rise: got edge %0d want %0d", e_p, T_P); end
    n_cmp++; if (e_ce != T_CE) begin n_bad++; $display("FAIL por_clk_enb_rise: got edge %0d want %0d", e_ce, T_CE); end
    n_cmp++; if (e_s != T_S) begin n_bad++; $display("FAIL por_s_rise: got edge %0d want %0d", e_s, T_S); end
    n_cmp++; if (e_busy != T_S) begin n_bad++; $display("FAIL por_busy_fall: got edge %0d want %0d", e_busy, T_S); end
    n_cmp++; if (e_cpu != T_S + 1) begin n_bad++; $display("FAIL por_cpu_rise: got edge %0d want %0d", e_cpu, T_S + 1); end
  endtask

  task automatic test_cpu_release();
    logic early_cpu;
    early_cpu = 1'b0;
    strap_riscv_rst = 1'b0;
    cpu_rst_release = 1'b0;
    hold_reset();
    @(posedge clk); #1;
    e_reset_n = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      @(posedge clk); #1;
      if (k <= 50 && cpu_reset_n) early_cpu = 1'b1;
      if (k == 50) begin
        n_cmp++; if (s_reset_n !== 1'b1) begin n_bad++; $display("FAIL cpu_s_up_at50: got %b want 1", s_reset_n); end
        cpu_rst_release = 1'b1;
      end
      if (k == 51) begin
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL cpu_at51: got %b want 0", cpu_reset_n); end
      end
      if (k == 52) begin
        n_cmp++; if (cpu_reset_n !== 1'b1) begin n_bad++; $display("FAIL cpu_at52: got %b want 1", cpu_reset_n); end
      end
    end
    n_cmp++; if (early_cpu !== 1'b0) begin n_bad++; $display("FAIL cpu_gated: got %b want 0", early_cpu); end
    cpu_rst_release = 1'b0;
    strap_riscv_rst = 1'b1;
  endtask

  task automatic test_soft_reboot();
    int k_fall, k_cefall, k_cerise, k_up, low;
    logic p_drop;
    soft_reboot(5, k_fall, k_cefall, k_cerise, k_up, p_drop);
    low = k_up - k_fall;
    n_cmp++; if (k_fall != 3) begin n_bad++; $display("FAIL rb_s_fall: got edge %0d want 3", k_fall); end
    n_cmp++; if (k_cefall != 4) begin n_bad++; $display("FAIL rb_clk_enb_fall: got edge %0d want 4", k_cefall); end
    n_cmp++; if (k_up - k_cerise != SRST_CYC) begin n_bad++; $display("FAIL rb_srst_wait: got %0d want %0d", k_up - k_cerise, SRST_CYC); end
    n_cmp++;
    if (low < REBOOT_CYC + 1 + SRST_CYC || low > REBOOT_CYC + 1 + CLKEN_CYC + SRST_CYC) begin
      n_bad++; $display("FAIL rb_low_time: got %0d want %0d..%0d", low, REBOOT_CYC + 1 + SRST_CYC, REBOOT_CYC + 1 + CLKEN_CYC + SRST_CYC);
    end
    n_cmp++; if (p_drop !== 1'b0) begin n_bad++; $display("FAIL rb_p_kept: got drop=%b want 0", p_drop); end
    n_cmp++; if (reboot_cnt !== 4'd1) begin n_bad++; $display("FAIL rb_count: got %0d want 1", reboot_cnt); end
    n_cmp++; if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL rb_busy_after: got %b want 0", seq_busy); end
  endtask

  task automatic test_stuck_request();
    int k_fall, k_cefall, k_cerise, k_up;
    logic p_drop, extra;
    soft_reboot(100, k_fall, k_cefall, k_cerise, k_up, p_drop);
    // request drops after edge 100; two sync flops put the exit at edge 103
    n_cmp++; if (k_cerise != 103) begin n_bad++; $display("FAIL stuck_exit: got edge %0d want 103", k_cerise); end
    n_cmp++; if (reboot_cnt !== 4'd2) begin n_bad++; $display("FAIL stuck_count: got %0d want 2", reboot_cnt); end
    extra = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!s_reset_n || seq_busy) extra = 1'b1;
    end
    n_cmp++; if (extra !== 1'b0 || reboot_cnt !== 4'd2) begin n_bad++; $display("FAIL stuck_single: got extra=%b cnt=%0d want extra=0 cnt=2", extra, reboot_cnt); end
  endtask

  task automatic test_mid_reset();
    int e_p, e_ce, e_s, e_cpu, e_busy;
    @(posedge clk); #1;
    strap_reboot_req = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_cmp++; if (s_reset_n !== 1'b0 || clk_enb !== 1'b0) begin n_bad++; $display("FAIL mid_in_hold: got s=%b ce=%b want 0 0", s_reset_n, clk_enb); end
    e_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({p_reset_n, clk_enb, s_reset_n, cpu_reset_n, seq_busy} !== 5'b00001 || reboot_cnt !== 4'd0) begin
      n_bad++; $display("FAIL mid_hold_async: got p/ce/s/cpu/busy=%b cnt=%0d want 00001 cnt=0",
                        {p_reset_n, clk_enb, s_reset_n, cpu_reset_n, seq_busy}, reboot_cnt);
    end
    hold_reset();
    @(posedge clk); #1;
    e_reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (p_reset_n !== 1'b1 || clk_enb !== 1'b0) begin n_bad++; $display("FAIL mid_in_clkwait: got p=%b ce=%b want 1 0", p_reset_n, clk_enb); end
    e_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({p_reset_n, clk_enb, s_reset_n, cpu_reset_n, seq_busy} !== 5'b00001) begin
      n_bad++; $display("FAIL mid_clkwait_async: got p/ce/s/cpu/busy=%b want 00001", {p_reset_n, clk_enb, s_reset_n, cpu_reset_n, seq_busy});
    end
    hold_reset();
    trace_por(e_p, e_ce, e_s, e_cpu, e_busy);
    n_cmp++;
    if (e_p != T_P || e_ce != T_CE || e_s != T_S) begin
      n_bad++; $display("FAIL mid_replay: got %0d/%0d/%0d want %0d/%0d/%0d", e_p, e_ce, e_s, T_P, T_CE, T_S);
    end
  endtask

  task automatic test_saturation();
    int k_fall, k_cefall, k_cerise, k_up;
    logic p_drop;
    for (int i = 1; i <= 17; i++) begin
      soft_reboot(5, k_fall, k_cefall, k_cerise, k_up, p_drop);
      n_cmp++;
      if (reboot_cnt !== 4'((i > 15) ? 15 : i)) begin
        n_bad++; $display("FAIL sat_count_%0d: got %0d want %0d", i, reboot_cnt, (i > 15) ? 15 : i);
      end
    end
  endtask

  task automatic test_req_in_prst();
    int k_up;
    hold_reset();
    @(posedge clk); #1;
    e_reset_n = 1'b1;
    for (int k = 1; k <= T_S + 1; k++) begin
      @(posedge clk); #1;
      if (k == 5) strap_reboot_req = 1'b1;
      if (k == T_S - 1) begin
        n_cmp++; if (s_reset_n !== 1'b0) begin n_bad++; $display("FAIL prst_req_early: got s=%b want 0", s_reset_n); end
      end
      if (k == T_S) begin
        n_cmp++; if (s_reset_n !== 1'b1 || seq_busy !== 1'b0) begin n_bad++; $display("FAIL prst_req_run: got s=%b busy=%b want 1 0", s_reset_n, seq_busy); end
      end
      if (k == T_S + 1) begin
        n_cmp++; if (s_reset_n !== 1'b0 || seq_busy !== 1'b1) begin n_bad++; $display("FAIL prst_req_serviced: got s=%b busy=%b want 0 1", s_reset_n, seq_busy); end
      end
    end
    strap_reboot_req = 1'b0;
    k_up = -1;
    for (int k = 1; k <= 200 && k_up < 0; k++) begin
      @(posedge clk); #1;
      if (s_reset_n) k_up = k;
    end
    n_cmp++; if (k_up < 0 || reboot_cnt !== 4'd1) begin n_bad++; $display("FAIL prst_req_done: got up=%0d cnt=%0d want up>0 cnt=1", k_up, reboot_cnt); end
  endtask

  initial begin
    test_reset();
    test_por();
    test_cpu_release();
    test_por();
    test_soft_reboot();
    test_stuck_request();
    test_mid_reset();
    test_saturation();
    test_req_in_prst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
